rf_wb_queue: RTL
================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 4, register address width; DATA_WIDTH, 32, write data width; DEPTH, 4, queue entries (power of two, >=2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 iAluVld  in  1  ALU writeback request valid.
REQ-005 oAluRdy  out  1  ALU request accepted this cycle when high with iAluVld.
REQ-006 iAluAddr  in  ADDR_WIDTH  ALU destination register.
REQ-007 iAluData  in  DATA_WIDTH  ALU result.
REQ-008 iLsuVld / oLsuRdy / iLsuAddr / iLsuData: same as REQ-004..007, for load-store unit.
REQ-009 oWrEn  out  1  register file write enable, registered.
REQ-010 oWrAddr  out  ADDR_WIDTH  register file write address, registered.
REQ-011 oWrData  out  DATA_WIDTH  register file write data, registered.
REQ-012 oPending  out  2**ADDR_WIDTH-1 (bits [N-1:1])  register has a write queued or on the write port.
REQ-013 oCount  out  clog2(DEPTH)+1  occupied queue entries.

Function
REQ-014 Handshake: transfer on a port SHALL occur in any cycle where Vld and Rdy are both high; Rdy SHALL NOT depend on that port's own Vld.
REQ-015 Free = DEPTH - oCount, from start-of-cycle occupancy; same-cycle pop SHALL NOT increase free space.
REQ-016 Free>=2: both Rdy high; simultaneous transfers enqueue ALU before LSU.
REQ-017 Free==1: Rdy high only for the port holding priority, or for the other port if the priority port's Vld is low; Free==0: both Rdy low.
REQ-018 Priority bit SHALL toggle to the other port after every cycle where Free==1 and both Vld are high; otherwise hold.
REQ-019 Requests with address 0 SHALL be accepted (Rdy rules unchanged) but not enqueued, and SHALL NOT count as occupancy.
REQ-020 Drain: when queue non-empty at a rising edge, the head SHALL pop into oWrEn/oWrAddr/oWrData (oWrEn=1); when empty, oWrEn=0 and addr/data hold.
REQ-021 Latency: a request transferred in cycle t into an empty queue SHALL appear with oWrEn=1 in cycle t+2; throughput one write per cycle.
REQ-022 Order: writes SHALL leave in enqueue order; two writes to one address reach the port oldest first.
REQ-023 oPending[i] SHALL be 1 iff a valid queue entry targets i or (oWrEn=1 and oWrAddr=i); combinational from state.
REQ-024 Pointers SHALL wrap modulo DEPTH; oCount SHALL never exceed DEPTH or underflow.

Reset
REQ-025 rst high SHALL immediately clear: oCount, read/write pointers, oWrEn, oWrAddr, oWrData, oPending to 0; priority to ALU.
REQ-026 Reset mid-operation SHALL discard all queued writes; no write issued after rst deasserts until a new transfer.

Structure
REQ-027 Package rf_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and typedef wb_entry_t {addr, data}.
REQ-028 Queue storage SHALL be sub-module wb_fifo (two push ports ordered, one pop port, count output); arbitration, output register and oPending remain in rf_wb_queue.

Verification
REQ-029 Single ALU write addr 5 data 0xDEADBEEF at cycle t -> oWrEn=1, oWrAddr=5, oWrData=0xDEADBEEF in cycle t+2 only; oPending[5]=1 from t+1 through t+2.
REQ-030 ALU addr 3 and LSU addr 3 same cycle, empty queue -> two consecutive writes, ALU data first then LSU data.
REQ-031 Both valid continuously, drain running: with Free==1 grants alternate ALU, LSU, ALU; oCount never exceeds 4; no request lost.
REQ-032 ALU write addr 0 -> oRdy high, oCount stays 0, oWrEn stays 0.
REQ-033 Fill 4 entries, assert rst for one cycle mid-drain -> oWrEn, oCount, oPending 0 immediately; no writes after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file writeback queue.
package rf_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 4;
    localparam int unsigned RF_DATA_WIDTH = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Which producer wins the last free slot.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    // Hand priority to the other producer.
    function automatic prio_e prio_flip(input prio_e p);
        prio_e r;
        case (p)
            PRIO_ALU: r = PRIO_LSU;
            PRIO_LSU: r = PRIO_ALU;
            default:  r = PRIO_ALU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Writeback storage: circular buffer with two ordered push ports
// (port A lands before port B in the same cycle) and one pop port.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = wb_entry_t,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_a_i,
    input  entry_t           data_a_i,
    input  logic             push_b_i,
    input  entry_t           data_b_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CW-1:0]    count_o,
    output entry_t           entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] wr_d;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] rd_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pop_s;
    logic [PW-1:0] wr_b_s;
    logic [PW-1:0] offset_s;

    // Never pop an empty buffer, whatever the caller asks.
    assign pop_s  = pop_i && (count_q != {CW{1'b0}});
    // Port B takes the slot after port A when both push together.
    assign wr_b_s = push_a_i ? (wr_q + PW'(1)) : wr_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_d    = wr_q + PW'(push_a_i) + PW'(push_b_i);
        count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_s);
        if (pop_s) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= {PW{1'b0}};
            rd_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_a_i) begin
                mem_q[wr_q] <= data_a_i;
            end
            if (push_b_i) begin
                mem_q[wr_b_s] <= data_b_i;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        valid_o  = {DEPTH{1'b0}};
        offset_s = {PW{1'b0}};
        for (int k = 0; k < int'(DEPTH); k++) begin
            offset_s   = PW'(k) - rd_q;
            valid_o[k] = ({1'b0, offset_s} < count_q);
        end
    end

    assign head_o    = mem_q[rd_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: arbitrates ALU and LSU results into a
// small FIFO and drains one write per cycle into a registered write port.
module rf_wb_queue
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iAluVld,
    output logic                         oAluRdy,
    input  logic [ADDR_WIDTH-1:0]        iAluAddr,
    input  logic [DATA_WIDTH-1:0]        iAluData,
    input  logic                         iLsuVld,
    output logic                         oLsuRdy,
    input  logic [ADDR_WIDTH-1:0]        iLsuAddr,
    input  logic [DATA_WIDTH-1:0]        iLsuData,
    output logic                         oWrEn,
    output logic [ADDR_WIDTH-1:0]        oWrAddr,
    output logic [DATA_WIDTH-1:0]        oWrData,
    output logic [(2**ADDR_WIDTH)-1:1]   oPending,
    output logic [$clog2(DEPTH):0]       oCount
);

    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } q_entry_t;

    q_entry_t          alu_ent_s;
    q_entry_t          lsu_ent_s;
    q_entry_t          head_s;
    q_entry_t          entries_s [DEPTH];
    logic [DEPTH-1:0]  valid_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     free_s;
    logic              alu_rdy_s;
    logic              lsu_rdy_s;
    logic              alu_push_s;
    logic              lsu_push_s;
    logic              pop_s;
    prio_e             prio_q;
    prio_e             prio_d;
    logic              wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [NREG-1:0]   pending_s;

    assign alu_ent_s = '{addr: iAluAddr, data: iAluData};
    assign lsu_ent_s = '{addr: iLsuAddr, data: iLsuData};

    // Free space is judged on start-of-cycle occupancy; a pop this cycle does not help.
    assign free_s = CW'(DEPTH) - count_s;

    // Grant rules: room for two grants both, one slot goes to the priority
    // port unless it is idle, a full queue grants nobody.
    always_comb begin
        alu_rdy_s = 1'b0;
        lsu_rdy_s = 1'b0;
        if (free_s >= CW'(2)) begin
            alu_rdy_s = 1'b1;
            lsu_rdy_s = 1'b1;
        end else if (free_s == CW'(1)) begin
            if (prio_q == PRIO_ALU) begin
                alu_rdy_s = 1'b1;
                lsu_rdy_s = ~iAluVld;
            end else begin
                lsu_rdy_s = 1'b1;
                alu_rdy_s = ~iLsuVld;
            end
        end else begin
            alu_rdy_s = 1'b0;
            lsu_rdy_s = 1'b0;
        end
    end

    assign oAluRdy = alu_rdy_s;
    assign oLsuRdy = lsu_rdy_s;

    // Writes to register 0 complete the handshake but are dropped.
    assign alu_push_s = iAluVld && alu_rdy_s && (iAluAddr != {ADDR_WIDTH{1'b0}});
    assign lsu_push_s = iLsuVld && lsu_rdy_s && (iLsuAddr != {ADDR_WIDTH{1'b0}});
    assign pop_s      = (count_s != {CW{1'b0}});

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (q_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_a_i  (alu_push_s),
        .data_a_i  (alu_ent_s),
        .push_b_i  (lsu_push_s),
        .data_b_i  (lsu_ent_s),
        .pop_i     (pop_s),
        .head_o    (head_s),
        .count_o   (count_s),
        .entries_o (entries_s),
        .valid_o   (valid_s)
    );

    // Priority flips only after a contested last slot.
    always_comb begin
        if ((free_s == CW'(1)) && iAluVld && iLsuVld) begin
            prio_d = prio_flip(prio_q);
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Write-port register: head of queue moves out every cycle it exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_WIDTH{1'b0}};
            wr_data_q <= {DATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= head_s.addr;
            wr_data_q <= head_s.data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign oWrEn   = wr_en_q;
    assign oWrAddr = wr_addr_q;
    assign oWrData = wr_data_q;
    assign oCount  = count_s;

    // A register is pending while queued or while sitting on the write port.
    always_comb begin
        pending_s = {NREG{1'b0}};
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (valid_s[k]) begin
                pending_s[entries_s[k].addr] = 1'b1;
            end
        end
        if (wr_en_q) begin
            pending_s[wr_addr_q] = 1'b1;
        end
    end

    assign oPending = pending_s[NREG-1:1];

endmodule
